// File: rtl/servo_pkg.sv
// Shared constants and types for the servo step controller.
package servo_pkg;

    localparam int ANG_W = 8;
    localparam int WID_W = 20;

    localparam int DEF_PERIOD_CYC  = 1_000_000;
    localparam int DEF_MIN_CYC     = 50_000;
    localparam int DEF_CYC_PER_DEG = 278;
    localparam int DEF_STEP_DEG    = 10;
    localparam int DEF_HOME_DEG    = 90;
    localparam int DEF_MAX_DEG     = 180;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SLEW_UP   = 2'd1,
        SLEW_DOWN = 2'd2
    } slew_state_t;

endpackage

// File: rtl/servo_step_ctrl_rise_detect.sv
// Single-flop rising-edge detector for an already-debounced button line.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev <= 1'b0;
        else      prev <= level;
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/servo_step_ctrl.sv
// Servo controller: buttons step a target angle, pos_cur slews one degree per PWM frame.
// state | meaning: IDLE at target | SLEW_UP stepping up | SLEW_DOWN stepping down
module servo_step_ctrl
    import servo_pkg::*;
#(
    parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
    parameter int MIN_CYC     = DEF_MIN_CYC,
    parameter int CYC_PER_DEG = DEF_CYC_PER_DEG,
    parameter int STEP_DEG    = DEF_STEP_DEG,
    parameter int HOME_DEG    = DEF_HOME_DEG,
    parameter int MAX_DEG     = DEF_MAX_DEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             btn_home,
    output logic             pwm_out,
    output logic [ANG_W-1:0] pos_tgt,
    output logic [ANG_W-1:0] pos_cur,
    output logic             busy
);

    logic             ev_inc, ev_dec, ev_home;
    logic [WID_W-1:0] cnt, width_q, width_nxt;
    logic             frame_end;
    logic [ANG_W-1:0] tgt_nxt, cur_nxt;
    logic [ANG_W:0]   tgt_up;
    slew_state_t      state, state_nxt;

    rise_detect u_rd_inc  (.clk(clk), .rst(rst), .level(btn_inc),  .rise(ev_inc));
    rise_detect u_rd_dec  (.clk(clk), .rst(rst), .level(btn_dec),  .rise(ev_dec));
    rise_detect u_rd_home (.clk(clk), .rst(rst), .level(btn_home), .rise(ev_home));

    assign frame_end = (cnt == WID_W'(PERIOD_CYC - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else      cnt <= frame_end ? '0 : cnt + WID_W'(1);
    end

    // 9-bit sum so the saturation compare cannot be fooled by wrap-around
    assign tgt_up = {1'b0, pos_tgt} + (ANG_W+1)'(STEP_DEG);

    always_comb begin
        tgt_nxt = pos_tgt;
        if (ev_home) begin
            tgt_nxt = ANG_W'(HOME_DEG);
        end else if (ev_inc && !ev_dec) begin
            tgt_nxt = (tgt_up > (ANG_W+1)'(MAX_DEG)) ? ANG_W'(MAX_DEG) : tgt_up[ANG_W-1:0];
        end else if (ev_dec && !ev_inc) begin
            tgt_nxt = (pos_tgt >= ANG_W'(STEP_DEG)) ? pos_tgt - ANG_W'(STEP_DEG) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pos_tgt <= ANG_W'(HOME_DEG);
        else      pos_tgt <= tgt_nxt;
    end

    always_comb begin
        state_nxt = state;
        cur_nxt   = pos_cur;
        if (frame_end) begin
            if (pos_cur < pos_tgt) begin
                state_nxt = SLEW_UP;
                cur_nxt   = pos_cur + ANG_W'(1);
            end else if (pos_cur > pos_tgt) begin
                state_nxt = SLEW_DOWN;
                cur_nxt   = pos_cur - ANG_W'(1);
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pos_cur <= ANG_W'(HOME_DEG);
        end else begin
            state   <= state_nxt;
            pos_cur <= cur_nxt;
        end
    end

    assign busy = (pos_cur != pos_tgt);

    // Width follows the freshly stepped angle so the new frame already uses it
    assign width_nxt = WID_W'(MIN_CYC) + WID_W'(cur_nxt) * WID_W'(CYC_PER_DEG);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            width_q <= WID_W'(MIN_CYC + HOME_DEG * CYC_PER_DEG);
            pwm_out <= 1'b0;
        end else begin
            if (frame_end) width_q <= width_nxt;
            pwm_out <= (cnt < width_q);
        end
    end

endmodule

// File: tb/tb_servo_step_ctrl.sv
// Scoreboard bench for servo_step_ctrl: a frame-level angle model predicts targets, steps and pulse widths.
module tb_servo_step_ctrl;

    localparam int P    = 2000;
    localparam int MINC = 100;
    localparam int CPD  = 5;
    localparam int STEP = 10;
    localparam int HOME = 90;
    localparam int MAXD = 180;

    logic       clk = 1'b0, rst = 1'b0;
    logic       btn_inc = 1'b0, btn_dec = 1'b0, btn_home = 1'b0;
    logic       pwm_out, busy;
    logic [7:0] pos_tgt, pos_cur;

    int checks = 0, errors = 0;
    int q_w[$];
    int q_cur[$];

    int m_tgt = HOME, m_cur = HOME, edges = 0;
    bit pi = 0, pd = 0, ph = 0, ei, ed, eh;

    servo_step_ctrl #(
        .PERIOD_CYC(P), .MIN_CYC(MINC), .CYC_PER_DEG(CPD),
        .STEP_DEG(STEP), .HOME_DEG(HOME), .MAX_DEG(MAXD)
    ) dut (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_home(btn_home),
        .pwm_out(pwm_out), .pos_tgt(pos_tgt), .pos_cur(pos_cur), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int width_of(input int deg);
        return MINC + deg * CPD;
    endfunction

    // Reference model: frame boundaries every P edges, one degree per frame, target rules on press events
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_tgt = HOME; m_cur = HOME; edges = 0;
            pi = 0; pd = 0; ph = 0;
            q_cur.delete();
            q_w.delete();
            q_w.push_back(width_of(HOME));
        end else begin
            edges++;
            if (edges % P == 0) begin
                if (m_cur != m_tgt) begin
                    m_cur = (m_cur < m_tgt) ? m_cur + 1 : m_cur - 1;
                    q_cur.push_back(m_cur);
                end
                q_w.push_back(width_of(m_cur));
            end
            ei = btn_inc && !pi;
            ed = btn_dec && !pd;
            eh = btn_home && !ph;
            if (eh)             m_tgt = HOME;
            else if (ei && !ed) m_tgt = (m_tgt + STEP > MAXD) ? MAXD : m_tgt + STEP;
            else if (ed && !ei) m_tgt = (m_tgt >= STEP) ? m_tgt - STEP : 0;
            pi = btn_inc; pd = btn_dec; ph = btn_home;
        end
    end

    int hi = 0, lo = 0, last_w = 0, exp_w;
    int seen_tgt = HOME, seen_mtgt = HOME, last_cur = HOME;
    bit seen_busy = 0, seen_mbusy = 0, prevp = 0, seen_fall = 0;

    always @(negedge clk) begin
        if (!rst) begin
            hi = 0; lo = 0; prevp = 0; seen_fall = 0;
            last_cur = HOME; seen_tgt = HOME; seen_mtgt = HOME;
            seen_busy = 0; seen_mbusy = 0;
        end else begin
            if (pos_tgt != seen_tgt || m_tgt != seen_mtgt) begin
                check("pos_tgt", int'(pos_tgt), m_tgt);
                seen_tgt = pos_tgt; seen_mtgt = m_tgt;
            end
            if (busy != seen_busy || (m_cur != m_tgt) != seen_mbusy) begin
                check("busy", int'(busy), int'(m_cur != m_tgt));
                seen_busy = busy; seen_mbusy = (m_cur != m_tgt);
            end
            if (pos_cur != last_cur) begin
                if (q_cur.size() == 0) check("pos_cur step not expected", int'(pos_cur), last_cur);
                else                   check("pos_cur step", int'(pos_cur), q_cur.pop_front());
                last_cur = pos_cur;
            end
            if (pwm_out) begin
                if (!prevp) begin
                    if (seen_fall) check("pwm low time", lo, P - last_w);
                    hi = 1;
                end else begin
                    hi++;
                end
            end else begin
                if (prevp) begin
                    if (q_w.size() == 0) begin
                        check("pwm pulse not expected", hi, 0);
                        exp_w = hi;
                    end else begin
                        exp_w = q_w.pop_front();
                        check("pwm high time", hi, exp_w);
                    end
                    last_w = exp_w;
                    seen_fall = 1;
                    lo = 1;
                end else begin
                    lo++;
                end
            end
            prevp = pwm_out;
        end
    end

    task automatic press(input bit i, input bit d, input bit h, input int len, input int gap);
        @(negedge clk);
        btn_inc = i; btn_dec = d; btn_home = h;
        repeat (len) @(negedge clk);
        btn_inc = 0; btn_dec = 0; btn_home = 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pwm(input logic lvl, input int budget);
        int k = 0;
        while (pwm_out != lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("pwm level reached in budget", int'(pwm_out), int'(lvl));
    endtask

    initial begin
        idle(3);
        check("reset pwm_out", int'(pwm_out), 0);
        check("reset pos_cur", int'(pos_cur), HOME);
        check("reset pos_tgt", int'(pos_tgt), HOME);
        check("reset busy", int'(busy), 0);
        rst = 1'b1;
        idle(2500);

        press(1, 0, 0, 40, 5);
        check("single inc target", int'(pos_tgt), 100);
        idle(21000);
        check("slew reached 100", int'(pos_cur), 100);
        check("busy clear at target", int'(busy), 0);

        for (int n = 0; n < 9; n++) press(1, 0, 0, 4, 3);
        check("inc saturates at max", int'(pos_tgt), MAXD);
        for (int n = 0; n < 19; n++) press(0, 1, 0, 4, 3);
        check("dec saturates at zero", int'(pos_tgt), 0);
        press(1, 1, 0, 3, 3);
        check("inc+dec no change", int'(pos_tgt), 0);
        press(0, 0, 1, 3, 3);
        for (int n = 0; n < 6; n++) press(1, 0, 0, 3, 3);
        check("target 150", int'(pos_tgt), 150);
        press(1, 0, 1, 3, 3);
        check("home beats inc", int'(pos_tgt), HOME);

        for (int n = 0; n < 3; n++) press(1, 0, 0, 3, 3);
        wait_pwm(1'b0, 2 * P);
        wait_pwm(1'b1, 2 * P);
        idle(200);
        check("pwm high before reset", int'(pwm_out), 1);
        #2 rst = 1'b0;
        #1;
        check("async reset pwm_out", int'(pwm_out), 0);
        check("async reset pos_cur", int'(pos_cur), HOME);
        check("async reset pos_tgt", int'(pos_tgt), HOME);
        check("async reset busy", int'(busy), 0);
        idle(3);
        rst = 1'b1;

        for (int n = 0; n < 3; n++) press(1, 0, 0, 3, 3);
        check("target 120", int'(pos_tgt), 120);
        idle(10000);
        check("five frames up", int'(pos_cur), 95);
        for (int n = 0; n < 4; n++) press(0, 1, 0, 3, 3);
        check("reversed target", int'(pos_tgt), 80);
        idle(8 * P);
        check("slewed down to 87", int'(pos_cur), 87);

        for (int n = 0; n < 40; n++)
            press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                  $urandom_range(1, 30), $urandom_range(1, 400));
        idle(2 * P);

        check("pending steps drained", q_cur.size(), 0);
        check("final pos_cur", int'(pos_cur), m_cur);
        check("final pos_tgt", int'(pos_tgt), m_tgt);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule
